// File: rtl/morse_keyer_tx.sv
// morse_keyer_tx: turns one Morse character (element count plus dot/dash
// pattern) into a timed key waveform on key_out.
// Timing uses units of UNIT_TICKS clock cycles: dot = 1 unit,
// dash = DASH_UNITS, inter-element gap = 1 unit. After the last element the
// trailing gap lasts CHAR_GAP_UNITS, or WORD_GAP_UNITS when sym_eow is set.
//
// Optional feature: define MORSE_KEYER_SIDETONE_EN to add a tone_out port.
// tone_out toggles every TONE_HALF_TICKS cycles during a mark and is 0
// otherwise.
//
// Handshake: a character transfers on any cycle where sym_valid && sym_ready.
// sym_ready is high only in IDLE. The upstream side may hold sym_valid
// through a busy period. Inputs are ignored until the keyer returns to IDLE.
// The done cycle is an IDLE cycle, so a back-to-back transfer costs no extra
// gap.
module morse_keyer_tx #(
  parameter int UNIT_TICKS      = 1000,
  parameter int DASH_UNITS      = 3,
  parameter int CHAR_GAP_UNITS  = 3,
  parameter int WORD_GAP_UNITS  = 7,
  parameter int TONE_HALF_TICKS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sym_valid,
  output logic       sym_ready,
  input  logic [2:0] sym_len,
  input  logic [4:0] sym_bits,
  input  logic       sym_eow,
  output logic       key_out,
  output logic       busy,
  output logic       done
`ifdef MORSE_KEYER_SIDETONE_EN
  ,
  output logic       tone_out
`endif
);

  localparam int TW     = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;
  localparam int MAX_U1 = (DASH_UNITS > CHAR_GAP_UNITS) ? DASH_UNITS : CHAR_GAP_UNITS;
  localparam int MAX_U  = (MAX_U1 > WORD_GAP_UNITS) ? MAX_U1 : WORD_GAP_UNITS;
  localparam int UW     = (MAX_U > 1) ? $clog2(MAX_U) : 1;

  // Catch parameter values the counters cannot represent.
  if (UNIT_TICKS < 2 || TONE_HALF_TICKS < 1 || DASH_UNITS < 1 ||
      CHAR_GAP_UNITS < 1 || WORD_GAP_UNITS < 1) begin : g_bad_param
    $error("morse_keyer_tx: unsupported parameter value");
  end

  typedef enum logic [1:0] {IDLE, MARK, ELEM_GAP, TAIL_GAP} state_t;

  // state is the FSM debug point; busy and sym_ready are decoded from it.
  state_t        state;
  state_t        state_next;
  logic [TW-1:0] tick;
  logic [UW-1:0] unit;
  logic [UW-1:0] last_unit;
  logic [2:0]    elem;
  logic [2:0]    len_r;
  logic [4:0]    bits_r;
  logic          eow_r;
  logic [2:0]    len_c;
  logic          take;
  logic          unit_end;
  logic          state_end;
  logic          key_d;
  logic          done_d;

  assign len_c     = (sym_len > 3'd5) ? 3'd5 : sym_len;
  assign take      = sym_valid && (state == IDLE);
  assign unit_end  = (tick == TW'(UNIT_TICKS - 1));
  assign state_end = unit_end && (unit == last_unit);
  assign sym_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Last unit index of the current state, from the captured character.
  always_comb begin
    last_unit = '0;
    case (state)
      MARK:     last_unit = bits_r[elem] ? UW'(DASH_UNITS - 1) : '0;
      ELEM_GAP: last_unit = '0;
      TAIL_GAP: last_unit = eow_r ? UW'(WORD_GAP_UNITS - 1) : UW'(CHAR_GAP_UNITS - 1);
      default:  last_unit = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; a space (len 0) goes straight to the trailing gap.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (take) state_next = (len_c == 3'd0) ? TAIL_GAP : MARK;
      MARK:     if (state_end) state_next = (elem == len_r - 3'd1) ? TAIL_GAP : ELEM_GAP;
      ELEM_GAP: if (state_end) state_next = MARK;
      TAIL_GAP: if (state_end) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Output decode: key follows the state being entered so key_out lines up with state.
  always_comb begin
    key_d  = (state_next == MARK);
    done_d = (state == TAIL_GAP) && state_end;
  end

  // Registered key and done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_out <= 1'b0;
      done    <= 1'b0;
    end else begin
      key_out <= key_d;
      done    <= done_d;
    end
  end

  // Tick and unit counters; restart on every state entry so durations are exact.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE || state_end) begin
      tick <= '0;
      unit <= '0;
    end else if (unit_end) begin
      tick <= '0;
      unit <= unit + 1'b1;
    end else begin
      tick <= tick + 1'b1;
    end
  end

  // Character capture at transfer; element index advances after each inter-element gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_r  <= '0;
      bits_r <= '0;
      eow_r  <= 1'b0;
      elem   <= '0;
    end else if (take) begin
      len_r  <= len_c;
      bits_r <= sym_bits;
      eow_r  <= sym_eow;
      elem   <= '0;
    end else if (state == ELEM_GAP && state_end) begin
      elem <= elem + 3'd1;
    end
  end

`ifdef MORSE_KEYER_SIDETONE_EN
  localparam int HW = (TONE_HALF_TICKS > 1) ? $clog2(TONE_HALF_TICKS) : 1;
  logic [HW-1:0] tone_div;

  // Sidetone divider: starts high at each mark, held cleared while the key is up.
  always_ff @(posedge clk) begin
    if (rst || !key_d) begin
      tone_out <= 1'b0;
      tone_div <= '0;
    end else if (!key_out) begin
      tone_out <= 1'b1;
      tone_div <= '0;
    end else if (tone_div == HW'(TONE_HALF_TICKS - 1)) begin
      tone_out <= ~tone_out;
      tone_div <= '0;
    end else begin
      tone_div <= tone_div + 1'b1;
    end
  end
`endif

endmodule
